// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage.
// Access sizes, FSM states and lane-width helper.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_CANCEL = 3'd4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store replication/strobes,
// load extraction with sign or zero extension.
module mem_lane_fmt
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int LANE_W = clog2(DATA_W / 8)
) (
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [DATA_W-1:0] sdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sgn;

    always_comb begin
        wdata_o = sdata_i;
        wstrb_o = '1;
        mask    = '1;
        sgn     = 1'b0;
        shifted = rdata_i >> {lane_i, 3'b000};
        unique case (size_i)
            SZ_B: begin
                wdata_o = {STRB_W{sdata_i[7:0]}};
                wstrb_o = STRB_W'(1) << lane_i;
                mask    = DATA_W'(8'hFF);
                sgn     = shifted[7];
            end
            SZ_H: begin
                wdata_o = {(STRB_W/2){sdata_i[15:0]}};
                wstrb_o = STRB_W'(3) << lane_i;
                mask    = DATA_W'(16'hFFFF);
                sgn     = shifted[15];
            end
            SZ_W: begin
                wdata_o = {(STRB_W/4){sdata_i[31:0]}};
                wstrb_o = STRB_W'(4'hF) << lane_i;
                mask    = DATA_W'(32'hFFFF_FFFF);
                sgn     = shifted[31];
            end
            default: ;
        endcase
        // a full-width mask leaves no bits to extend
        rdata_o = (shifted & mask)
                | ({DATA_W{sgn & ~uns_i}} & ~mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage between EXE and WB with a
// req/addr_ok/data_ok data-memory handshake.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int PAYLOAD_W = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_load,
    input  logic                   op_store,
    input  logic [1:0]             op_size,
    input  logic                   op_unsigned,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      store_data,
    input  logic [PAYLOAD_W-1:0]   payload_in,
    input  logic                   flush,
    output logic                   dm_req,
    output logic                   dm_wr,
    output logic [ADDR_W-1:0]      dm_addr,
    output logic [DATA_W/8-1:0]    dm_wstrb,
    output logic [DATA_W-1:0]      dm_wdata,
    input  logic                   dm_addr_ok,
    input  logic                   dm_data_ok,
    input  logic [DATA_W-1:0]      dm_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      result,
    output logic                   ex_adel,
    output logic                   ex_ades,
    output logic [ADDR_W-1:0]      badvaddr,
    output logic [PAYLOAD_W-1:0]   payload_out
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = clog2(STRB_W);

    logic [2:0]           state_q, state_d;
    logic                 ld_q, st_q, uns_q;
    logic [1:0]           size_q;
    logic [ADDR_W-1:0]    addr_q, badv_q;
    logic [DATA_W-1:0]    sdata_q, result_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 adel_q, ades_q;

    logic              accept, misal, is_mem;
    logic [2:0]        dest, amask;
    logic [DATA_W-1:0] wdata, fmt_rdata;
    logic [STRB_W-1:0] wstrb;

    assign in_ready = (state_q == ST_IDLE)
                    | ((state_q == ST_HOLD) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign is_mem   = op_load | op_store;

    always_comb begin
        misal = 1'b0;
        unique case (op_size)
            SZ_B:    misal = 1'b0;
            SZ_H:    misal = addr[0];
            SZ_W:    misal = |addr[1:0];
            default: misal = (DATA_W == 32) | (|addr[2:0]);
        endcase
        dest = (is_mem & ~misal) ? ST_REQ : ST_HOLD;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                state_d = accept ? dest : ST_IDLE;
            ST_REQ:
                if (dm_addr_ok)
                    state_d = flush ? ST_CANCEL : ST_WAIT;
                else if (flush)
                    state_d = ST_IDLE;
            ST_WAIT:
                if (dm_data_ok)
                    state_d = flush ? ST_IDLE : ST_HOLD;
                else if (flush)
                    state_d = ST_CANCEL;
            ST_HOLD:
                if (flush)
                    state_d = ST_IDLE;
                else if (out_ready)
                    state_d = accept ? dest : ST_IDLE;
            ST_CANCEL:
                if (dm_data_ok)
                    state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= SZ_B;
            addr_q    <= '0;
            sdata_q   <= '0;
            payload_q <= '0;
            result_q  <= '0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
            badv_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ld_q      <= op_load;
                st_q      <= op_store;
                uns_q     <= op_unsigned;
                size_q    <= op_size;
                addr_q    <= addr;
                sdata_q   <= store_data;
                payload_q <= payload_in;
                result_q  <= DATA_W'(addr);
                adel_q    <= op_load & misal;
                ades_q    <= op_store & misal;
                if (misal & is_mem)
                    badv_q <= addr;
            end
            if ((state_q == ST_WAIT) & dm_data_ok
                & ~flush & ld_q)
                result_q <= fmt_rdata;
        end
    end

    always_comb begin
        unique case (size_q)
            SZ_B:    amask = 3'b000;
            SZ_H:    amask = 3'b001;
            SZ_W:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
    end

    mem_lane_fmt #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .LANE_W (LANE_W)
    ) u_fmt (
        .size_i  (size_q),
        .uns_i   (uns_q),
        .lane_i  (addr_q[LANE_W-1:0]),
        .sdata_i (sdata_q),
        .rdata_i (dm_rdata),
        .wdata_o (wdata),
        .wstrb_o (wstrb),
        .rdata_o (fmt_rdata)
    );

    assign dm_req      = (state_q == ST_REQ);
    assign dm_wr       = dm_req & st_q;
    assign dm_addr     = addr_q & ~ADDR_W'(amask);
    assign dm_wstrb    = dm_wr ? wstrb : '0;
    assign dm_wdata    = wdata;
    assign out_valid   = (state_q == ST_HOLD);
    assign result      = result_q;
    assign ex_adel     = adel_q;
    assign ex_ades     = ades_q;
    assign badvaddr    = badv_q;
    assign payload_out = payload_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: random ops
// against a byte-array memory model, plus directed cases.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, op_load, op_store;
    logic [1:0]  op_size;
    logic        op_unsigned, flush;
    logic [31:0] addr, store_data;
    logic [63:0] payload_in, payload_out;
    logic        dm_req, dm_wr, dm_addr_ok, dm_data_ok;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic        out_valid, out_ready, ex_adel, ex_ades;
    logic [31:0] result, badvaddr;

    mem_access_unit #(
        .DATA_W(32), .ADDR_W(32), .PAYLOAD_W(64)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_load(op_load), .op_store(op_store),
        .op_size(op_size), .op_unsigned(op_unsigned),
        .addr(addr), .store_data(store_data),
        .payload_in(payload_in), .flush(flush),
        .dm_req(dm_req), .dm_wr(dm_wr),
        .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_addr_ok(dm_addr_ok),
        .dm_data_ok(dm_data_ok), .dm_rdata(dm_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ex_adel(ex_adel),
        .ex_ades(ex_ades), .badvaddr(badvaddr),
        .payload_out(payload_out)
    );

    // 64-bit instance for the doubleword cases
    logic        iv64, ir64, ld64, uns64;
    logic [1:0]  sz64;
    logic [31:0] a64, dma64, bv64;
    logic [63:0] sd64, pl64, plo64, dmw64, rd64, res64;
    logic        req64, wr64, aok64, dok64;
    logic        ov64, ea64, es64, fl64, ordy64;
    logic [7:0]  ws64;

    mem_access_unit #(
        .DATA_W(64), .ADDR_W(32), .PAYLOAD_W(64)
    ) u_dut64 (
        .clk(clk), .reset(reset),
        .in_valid(iv64), .in_ready(ir64),
        .op_load(ld64), .op_store(1'b0),
        .op_size(sz64), .op_unsigned(uns64),
        .addr(a64), .store_data(sd64),
        .payload_in(pl64), .flush(fl64),
        .dm_req(req64), .dm_wr(wr64),
        .dm_addr(dma64), .dm_wstrb(ws64),
        .dm_wdata(dmw64), .dm_addr_ok(aok64),
        .dm_data_ok(dok64), .dm_rdata(rd64),
        .out_valid(ov64), .out_ready(ordy64),
        .result(res64), .ex_adel(ea64),
        .ex_ades(es64), .badvaddr(bv64),
        .payload_out(plo64)
    );

    typedef struct packed {
        logic [31:0] result;
        logic        chk_res;
        logic        adel;
        logic        ades;
        logic [31:0] badv;
        logic [63:0] payload;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [7:0]  ref_mem [256];
    logic [31:0] mem [64];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_req = 0;
    int req_cycles = 0;
    int a_lat = 0;
    int d_lat = 0;
    bit rand_lat = 0;
    bit or_rand = 0;
    logic [31:0] last_result;
    logic [3:0]  last_strb;
    logic [31:0] last_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h",
                     nm, got, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got=timeout expected=event", nm);
    endtask

    // Reference: byte-addressed memory, little endian.
    function automatic void model(
        input logic ld, input logic st,
        input logic [1:0] sz, input logic uns,
        input logic [31:0] a, input logic [31:0] sd,
        input logic [63:0] pl, input bit track);
        int   nb;
        bit   mis;
        exp_t e;
        req_t r;
        logic [31:0] v;
        nb = 1 << sz;
        mis = (sz == 2'd3) || ((a % nb) != 0);
        e.payload = pl;
        e.adel = ld && mis;
        e.ades = st && mis;
        e.badv = a;
        e.result = a;
        e.chk_res = !((ld || st) && mis);
        if ((ld || st) && !mis) begin
            r.addr = a;
            r.wr = st;
            r.strb = '0;
            r.wdata = '0;
            if (st) begin
                for (int i = 0; i < 4; i++) begin
                    r.wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
                    r.strb[i] = (i >= (a % 4))
                             && (i < (a % 4) + nb);
                end
                for (int k = 0; k < nb; k++)
                    ref_mem[8'(a + k)] = sd[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < nb; k++)
                    v[8*k +: 8] = ref_mem[8'(a + k)];
                if (!uns && nb < 4 && v[8*nb-1])
                    v = v | ~((32'h1 << (8*nb)) - 1);
                e.result = v;
            end
            req_q.push_back(r);
        end
        if (track) exp_q.push_back(e);
    endfunction

    task automatic issue(input logic ld, input logic st,
                         input logic [1:0] sz,
                         input logic uns,
                         input logic [31:0] a,
                         input logic [31:0] sd,
                         input bit track,
                         output int waited);
        logic [63:0] pl;
        pl = {$urandom, $urandom};
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op_load = ld;
        op_store = st;
        op_size = sz;
        op_unsigned = uns;
        addr = a;
        store_data = sd;
        payload_in = pl;
        #1;
        while (!in_ready && waited < 60) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) fail("accept_timeout");
        else begin
            acc_cyc = cyc;
            model(ld, st, sz, uns, a, sd, pl, track);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat,
                            output int busy);
        busy = 0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
            if (in_ready) busy++;
        end
        if (lat < 0) fail("out_valid_timeout");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0)
               && n < 300) begin
            @(negedge clk);
            n++;
        end
        #3;
        if (exp_q.size() != 0 || req_q.size() != 0)
            fail("drain");
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = or_rand ? ($urandom_range(0, 3) != 0)
                                : 1'b1;
        end
    end

    // Memory responder with configurable latency.
    initial begin : resp
        int hold;
        int a_cur;
        int d_cur;
        req_t e;
        logic [31:0] ra, rd;
        logic        rw;
        logic [3:0]  rs;
        hold = 0;
        a_cur = 0;
        d_cur = 0;
        ra = '0;
        rw = 1'b0;
        dm_addr_ok = 1'b0;
        dm_data_ok = 1'b0;
        dm_rdata = '0;
        forever begin
            @(negedge clk);
            dm_addr_ok = 1'b0;
            dm_data_ok = 1'b0;
            if (reset || !dm_req) hold = 0;
            else begin
                if (hold == 0) begin
                    ra = dm_addr;
                    rw = dm_wr;
                    a_cur = rand_lat ? $urandom_range(0, 2)
                                     : a_lat;
                    d_cur = rand_lat ? $urandom_range(0, 2)
                                     : d_lat;
                end else begin
                    chk("req_addr_stable", dm_addr, ra);
                    chk("req_wr_stable", dm_wr, rw);
                end
                hold++;
                if (hold > a_cur) begin
                    dm_addr_ok = 1'b1;
                    req_cycles = hold;
                    hold = 0;
                    n_req++;
                    rs = dm_wstrb;
                    rd = dm_wdata;
                    last_strb = rs;
                    last_wdata = rd;
                    if (req_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL req_unexpected: got=%h expected=none",
                                 ra);
                    end else begin
                        e = req_q.pop_front();
                        chk("req_addr", ra, e.addr);
                        chk("req_wr", rw, e.wr);
                        if (e.wr) begin
                            chk("req_strb", rs, e.strb);
                            chk("req_wdata", rd, e.wdata);
                        end
                    end
                    @(negedge clk);
                    dm_addr_ok = 1'b0;
                    repeat (d_cur) @(negedge clk);
                    dm_data_ok = 1'b1;
                    if (rw) begin
                        for (int i = 0; i < 4; i++)
                            if (rs[i])
                                mem[ra[7:2]][8*i +: 8] = rd[8*i +: 8];
                    end else begin
                        dm_rdata = mem[ra[7:2]];
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got=%h expected=none",
                             result);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_res) chk("result", result, e.result);
                    chk("ex_adel", ex_adel, e.adel);
                    chk("ex_ades", ex_ades, e.ades);
                    if (e.adel || e.ades)
                        chk("badvaddr", badvaddr, e.badv);
                    chk("payload", payload_out, e.payload);
                    last_result = result;
                end
            end
        end
    end

    initial begin : resp64
        aok64 = 1'b0;
        dok64 = 1'b0;
        forever begin
            @(negedge clk);
            dok64 = aok64;
            aok64 = req64;
        end
    end

    task automatic run64(input logic [1:0] sz,
                         input logic uns,
                         input logic [31:0] a,
                         input logic [63:0] rd,
                         output logic [63:0] res);
        bit seen;
        seen = 0;
        res = '0;
        rd64 = rd;
        @(negedge clk);
        iv64 = 1'b1;
        ld64 = 1'b1;
        sz64 = sz;
        uns64 = uns;
        a64 = a;
        @(posedge clk);
        #1;
        iv64 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov64) begin
                res = res64;
                seen = 1;
                break;
            end
        end
        if (!seen) fail("out64_timeout");
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w, lat, busy, nr, ovc, k;
        bit got_ok;
        logic ld, st;
        logic [1:0] sz;
        logic [31:0] a, word;
        logic [63:0] r64;

        reset = 1'b1;
        in_valid = 1'b0;
        op_load = 1'b0;
        op_store = 1'b0;
        op_size = SZ_B;
        op_unsigned = 1'b0;
        addr = '0;
        store_data = '0;
        payload_in = '0;
        flush = 1'b0;
        iv64 = 1'b0;
        ld64 = 1'b0;
        sz64 = SZ_B;
        uns64 = 1'b0;
        a64 = '0;
        sd64 = '0;
        pl64 = '0;
        fl64 = 1'b0;
        ordy64 = 1'b1;
        rd64 = '0;
        for (int i = 0; i < 64; i++) begin
            word = $urandom;
            mem[i] = word;
            for (int b = 0; b < 4; b++)
                ref_mem[4*i + b] = word[8*b +: 8];
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_dm_req", dm_req, 1'b0);
        chk("rst_dm_wr", dm_wr, 1'b0);
        chk("rst_dm_wstrb", dm_wstrb, 4'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ex_adel", ex_adel, 1'b0);
        chk("rst_ex_ades", ex_ades, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_badvaddr", badvaddr, 32'h0);
        chk("rst_payload", payload_out, 64'h0);

        issue(1'b0, 1'b1, SZ_B, 1'b0, 32'h1003,
              32'h0000_00AB, 1, w);
        wait_out(lat, busy);
        chk("sb_latency", lat, 3);
        chk("sb_wstrb", last_strb, 4'b1000);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        drain();
        chk("sb_result", last_result, 32'h1003);

        issue(1'b0, 1'b1, SZ_W, 1'b0, 32'h2000,
              32'h12F4_5678, 1, w);
        issue(1'b1, 1'b0, SZ_B, 1'b0, 32'h2002,
              32'h0, 1, w);
        drain();
        chk("lb_result", last_result, 32'hFFFF_FFF4);
        issue(1'b1, 1'b0, SZ_H, 1'b1, 32'h2002,
              32'h0, 1, w);
        drain();
        chk("lhu_result", last_result, 32'h0000_12F4);

        nr = n_req;
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h3002,
              32'h0, 1, w);
        wait_out(lat, busy);
        chk("lw_mis_latency", lat, 1);
        chk("lw_mis_adel", ex_adel, 1'b1);
        chk("lw_mis_badvaddr", badvaddr, 32'h3002);
        drain();
        issue(1'b0, 1'b1, SZ_H, 1'b0, 32'h3001,
              32'h0, 1, w);
        wait_out(lat, busy);
        chk("sh_mis_ades", ex_ades, 1'b1);
        drain();
        chk("mis_no_req", n_req, nr);

        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h0BAD_0001,
              32'h0, 1, w);
        wait_out(lat, busy);
        chk("pass_latency", lat, 1);
        drain();

        a_lat = 4;
        d_lat = 3;
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h40,
              32'h0, 1, w);
        wait_out(lat, busy);
        chk("slow_req_cycles", req_cycles, 5);
        chk("slow_in_ready_low", busy, 0);
        chk("slow_latency", lat, 10);
        drain();
        for (int i = 0; i < 4; i++)
            issue(1'(i % 2), 1'(1 - i % 2), SZ_W, 1'b0,
                  32'h80 + 32'(4 * (i / 2)),
                  $urandom, 1, w);
        drain();

        a_lat = 0;
        d_lat = 3;
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h44,
              32'h0, 0, w);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("cancel_in_ready", in_ready, 1'b0);
        ovc = 0;
        got_ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) ovc++;
            if (dm_data_ok) begin
                got_ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!got_ok) fail("cancel_data_ok");
        chk("cancel_no_out_valid", ovc, 0);
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h48,
              32'h0, 1, w);
        chk("post_cancel_accept_wait", w, 0);
        drain();

        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        op_load = 1'b1;
        op_store = 1'b0;
        op_size = SZ_W;
        addr = 32'h4C;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_dom_req", dm_req, 1'b0);
        chk("flush_dom_out_valid", out_valid, 1'b0);

        rand_lat = 1;
        or_rand = 1;
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 9);
            ld = (k < 4);
            st = (k >= 4 && k < 7);
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = a & ~32'((1 << sz) - 1);
            issue(ld, st, sz, 1'($urandom_range(0, 1)),
                  a, $urandom, 1, w);
        end
        drain();
        or_rand = 0;

        run64(SZ_D, 1'b0, 32'h8,
              64'h8000_0000_0000_0001, r64);
        chk("ld64_result", r64, 64'h8000_0000_0000_0001);
        run64(SZ_W, 1'b0, 32'hC,
              64'h8000_0000_0000_0001, r64);
        chk("lw64_result", r64, 64'hFFFF_FFFF_8000_0000);
        run64(SZ_W, 1'b1, 32'hC,
              64'h8000_0000_0000_0001, r64);
        chk("lwu64_result", r64, 64'h0000_0000_8000_0000);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
